// File: rtl/tx_frame_controller_if.sv
// Handshake and shift-register control bundle between the TX frame controller and its neighbours.
// The master side drives requests and data; the slave side is the controller itself.
interface tx_frame_controller_if;
    logic        tx_req;
    logic        stop;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_ready;
    logic        sda_in;
    logic [31:0] data_out;
    logic        load_rdata;
    logic        enable_desp;
    logic        sda_oe;
    logic        busy;
    logic        nack_early;
    logic [7:0]  word_cnt;

    modport master (
        output tx_req, stop, word_valid, word_in, sda_in,
        input  word_ready, data_out, load_rdata, enable_desp, sda_oe, busy, nack_early, word_cnt
    );

    modport slave (
        input  tx_req, stop, word_valid, word_in, sda_in,
        output word_ready, data_out, load_rdata, enable_desp, sda_oe, busy, nack_early, word_cnt
    );
endinterface

// File: rtl/tx_frame_controller.sv
// Sequences 32-bit words into four MSB-first bytes with a master ACK slot after each byte,
// driving load/shift strobes for the SCL-domain shift register from the SCL rising edge.
module tx_frame_controller #(
    parameter int unsigned WORD_BYTES = 4
) (
    input logic                  scl,
    input logic                  rst,
    tx_frame_controller_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StLoad,
        StShift,
        StAck,
        StDone
    } state_e;

    localparam logic [2:0] LastByte = 3'(WORD_BYTES);

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] data_out_q, data_out_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic        word_ready_q, word_ready_d;
    logic        load_rdata_q, load_rdata_d;
    logic        enable_desp_q, enable_desp_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        nack_early_q, nack_early_d;
    logic        accept;

    // Next state and counters; stop overrides every other transition.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        data_out_d   = data_out_q;
        word_cnt_d   = word_cnt_q;
        nack_early_d = 1'b0;
        accept       = 1'b0;

        if (bus.stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.tx_req) state_d = StWaitData;
                end
                StWaitData: begin
                    if (bus.word_valid && word_ready_q) begin
                        accept  = 1'b1;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    state_d   = StShift;
                    bit_cnt_d = 3'd1;
                end
                StShift: begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        state_d    = StAck;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                StAck: begin
                    if (bus.sda_in) begin
                        // A NACK never transfers a word, even with word_ready high.
                        state_d      = StDone;
                        nack_early_d = (byte_cnt_q < LastByte);
                    end else if (byte_cnt_q < LastByte) begin
                        state_d   = StShift;
                        bit_cnt_d = 3'd0;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        if (bus.word_valid && word_ready_q) begin
                            accept  = 1'b1;
                            state_d = StLoad;
                        end else begin
                            state_d = StWaitData;
                        end
                    end
                end
                StDone: begin
                    if (!bus.tx_req) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        if (accept) begin
            data_out_d = bus.word_in;
            byte_cnt_d = 3'd0;
        end
    end

    // Outputs decode the state being entered so they are registered alongside it.
    always_comb begin
        word_ready_d  = 1'b0;
        load_rdata_d  = 1'b0;
        enable_desp_d = 1'b0;
        sda_oe_d      = 1'b0;
        busy_d        = (state_d != StIdle);
        unique case (state_d)
            StWaitData: word_ready_d = 1'b1;
            StLoad: begin
                load_rdata_d = 1'b1;
                sda_oe_d     = 1'b1;
            end
            StShift: begin
                enable_desp_d = 1'b1;
                sda_oe_d      = 1'b1;
            end
            StAck:   word_ready_d = (byte_cnt_d == LastByte);
            default: ;
        endcase
    end

    always_ff @(posedge scl or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 3'd0;
            data_out_q    <= 32'd0;
            word_cnt_q    <= 8'd0;
            word_ready_q  <= 1'b0;
            load_rdata_q  <= 1'b0;
            enable_desp_q <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            nack_early_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            data_out_q    <= data_out_d;
            word_cnt_q    <= word_cnt_d;
            word_ready_q  <= word_ready_d;
            load_rdata_q  <= load_rdata_d;
            enable_desp_q <= enable_desp_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            nack_early_q  <= nack_early_d;
        end
    end

    assign bus.word_ready  = word_ready_q;
    assign bus.data_out    = data_out_q;
    assign bus.load_rdata  = load_rdata_q;
    assign bus.enable_desp = enable_desp_q;
    assign bus.sda_oe      = sda_oe_q;
    assign bus.busy        = busy_q;
    assign bus.nack_early  = nack_early_q;
    assign bus.word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed bench for tx_frame_controller with a falling-edge shift-register model on the output.
module tb_tx_frame_controller;

    logic scl = 1'b0;
    logic rst = 1'b1;
    always #5 scl = ~scl;

    tx_frame_controller_if bus ();

    tx_frame_controller #(.WORD_BYTES(4)) dut (
        .scl (scl),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Shift register: loads or shifts on the falling edge, MSB drives SDA.
    logic [31:0] sr;
    always @(negedge scl) begin
        if (bus.load_rdata)       sr <= bus.data_out;
        else if (bus.enable_desp) sr <= {sr[30:0], 1'b0};
    end

    int           edge_no, nbits, load_cnt, nack_cnt, overlap_cnt;
    logic [127:0] stream;
    logic [127:0] oe_hist;
    logic [127:0] oe_exp;
    logic [5:0]   ctl;
    assign ctl = {bus.word_ready, bus.load_rdata, bus.enable_desp, bus.sda_oe, bus.busy,
                  bus.nack_early};

    task automatic mon_clear();
        edge_no = 0; nbits = 0; load_cnt = 0; nack_cnt = 0; overlap_cnt = 0;
        stream = '0; oe_hist = '0;
    endtask

    // Record what the next rising edge sees, then advance past that edge.
    task automatic tick();
        @(negedge scl); #1;
        edge_no++;
        if (edge_no < 128) oe_hist[edge_no] = bus.sda_oe;
        if (bus.sda_oe) begin
            stream = {stream[126:0], sr[31]};
            nbits++;
        end
        if (bus.load_rdata) load_cnt++;
        if (bus.nack_early) nack_cnt++;
        if (bus.load_rdata && bus.enable_desp) overlap_cnt++;
        @(posedge scl); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tx_req = 1'b0; bus.stop = 1'b0; bus.word_valid = 1'b0;
        bus.word_in = 32'd0; bus.sda_in = 1'b0;
        repeat (2) @(posedge scl);
        #1 rst = 1'b0;
    endtask

    // Leaves the bench just after the accept edge E0.
    task automatic start_word(input logic [31:0] w);
        bus.tx_req = 1'b1;
        tick();
        bus.word_valid = 1'b1;
        bus.word_in    = w;
        tick();
        bus.word_valid = 1'b0;
        mon_clear();
    endtask

    function automatic void build_oe_exp(input int edges);
        oe_exp = '0;
        for (int k = 1; k <= edges; k++) oe_exp[k] = (k % 9 != 0);
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ctl !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000000", ctl);
        end
        n_cmp++;
        if (bus.data_out !== 32'd0) begin
            n_bad++; $display("FAIL reset_data_out: got %h want 0", bus.data_out);
        end
        n_cmp++;
        if (bus.word_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_word_cnt: got %0d want 0", bus.word_cnt);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        start_word(32'hA5C3_0F81);
        n_cmp++;
        if (ctl !== 6'b010110 || bus.data_out !== 32'hA5C3_0F81) begin
            n_bad++; $display("FAIL single_load: ctl %b data %h want 010110 a5c30f81",
                              ctl, bus.data_out);
        end
        bus.word_in = 32'hFFFF_FFFF;
        repeat (36) tick();
        build_oe_exp(36);
        n_cmp++;
        if (oe_hist[36:1] !== oe_exp[36:1]) begin
            n_bad++; $display("FAIL single_oe: got %b want %b", oe_hist[36:1], oe_exp[36:1]);
        end
        n_cmp++;
        if (nbits !== 32 || stream[31:0] !== 32'hA5C3_0F81) begin
            n_bad++; $display("FAIL single_stream: got %0d bits %h want 32 bits a5c30f81",
                              nbits, stream[31:0]);
        end
        n_cmp++;
        if (bus.word_cnt !== 8'd1 || ctl !== 6'b100010) begin
            n_bad++; $display("FAIL single_end: word_cnt %0d ctl %b want 1 100010",
                              bus.word_cnt, ctl);
        end
        // Second word, NACKed after its first byte.
        bus.word_valid = 1'b1;
        bus.word_in    = 32'h3C3C_3C3C;
        tick();
        bus.word_valid = 1'b0;
        repeat (8) tick();
        bus.sda_in = 1'b1;
        tick();
        bus.sda_in = 1'b0;
        n_cmp++;
        if (ctl !== 6'b000011) begin
            n_bad++; $display("FAIL single_nack: ctl %b want 000011", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 6'b000010 || bus.word_cnt !== 8'd1) begin
            n_bad++; $display("FAIL single_done: ctl %b word_cnt %0d want 000010 1",
                              ctl, bus.word_cnt);
        end
        bus.tx_req = 1'b0;
        tick();
        n_cmp++;
        if (nack_cnt !== 1 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL single_nack_pulses: pulses %0d busy %b want 1 0",
                              nack_cnt, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_word(32'h1234_5678);
        bus.word_valid = 1'b1;
        bus.word_in    = 32'h9ABC_DEF0;
        for (int i = 1; i <= 72; i++) begin
            tick();
            if (i == 36) bus.word_valid = 1'b0;
        end
        build_oe_exp(72);
        n_cmp++;
        if (oe_hist[72:1] !== oe_exp[72:1]) begin
            n_bad++; $display("FAIL b2b_oe: got %b want %b", oe_hist[72:1], oe_exp[72:1]);
        end
        n_cmp++;
        if (nbits !== 64 || stream[63:0] !== 64'h1234_5678_9ABC_DEF0) begin
            n_bad++; $display("FAIL b2b_stream: got %0d bits %h want 64 bits 123456789abcdef0",
                              nbits, stream[63:0]);
        end
        n_cmp++;
        if (load_cnt !== 2 || overlap_cnt !== 0) begin
            n_bad++; $display("FAIL b2b_loads: loads %0d overlaps %0d want 2 0",
                              load_cnt, overlap_cnt);
        end
        n_cmp++;
        if (bus.word_cnt !== 8'd2 || bus.data_out !== 32'h9ABC_DEF0) begin
            n_bad++; $display("FAIL b2b_end: word_cnt %0d data %h want 2 9abcdef0",
                              bus.word_cnt, bus.data_out);
        end
    endtask

    task automatic test_nack_byte2();
        do_reset();
        start_word(32'hDEAD_BEEF);
        repeat (4) tick();
        bus.tx_req = 1'b0;  // must not end the word
        repeat (13) tick();
        bus.sda_in = 1'b1;
        tick();
        bus.sda_in = 1'b0;
        n_cmp++;
        if (nbits !== 16 || stream[15:0] !== 16'hDEAD) begin
            n_bad++; $display("FAIL nack2_stream: got %0d bits %h want 16 bits dead",
                              nbits, stream[15:0]);
        end
        n_cmp++;
        if (ctl !== 6'b000011) begin
            n_bad++; $display("FAIL nack2_pulse: ctl %b want 000011", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 6'b000000 || bus.word_cnt !== 8'd0) begin
            n_bad++; $display("FAIL nack2_idle: ctl %b word_cnt %0d want 000000 0",
                              ctl, bus.word_cnt);
        end
    endtask

    task automatic test_nack_last();
        do_reset();
        start_word(32'h1122_3344);
        repeat (35) tick();
        bus.sda_in     = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_in    = 32'h5566_7788;
        tick();
        bus.sda_in = 1'b0;
        n_cmp++;
        if (ctl !== 6'b000010 || bus.word_cnt !== 8'd0 || bus.data_out !== 32'h1122_3344) begin
            n_bad++; $display("FAIL nack_last: ctl %b word_cnt %0d data %h want 000010 0 11223344",
                              ctl, bus.word_cnt, bus.data_out);
        end
        bus.tx_req     = 1'b0;
        bus.word_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL nack_last_idle: busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_stop_byte3();
        do_reset();
        start_word(32'h0F0F_1234);
        repeat (21) tick();
        n_cmp++;
        if (ctl !== 6'b001110) begin
            n_bad++; $display("FAIL stop_pre: ctl %b want 001110", ctl);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_cmp++;
        if (ctl !== 6'b000000 || bus.data_out !== 32'h0F0F_1234) begin
            n_bad++; $display("FAIL stop_idle: ctl %b data %h want 000000 0f0f1234",
                              ctl, bus.data_out);
        end
        tick();
        n_cmp++;
        if (ctl !== 6'b100010) begin
            n_bad++; $display("FAIL stop_restart: ctl %b want 100010", ctl);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_word(32'hCAFE_F00D);
        bus.word_valid = 1'b1;
        bus.word_in    = 32'h0BAD_BEEF;
        repeat (36) tick();
        bus.word_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bus.word_cnt !== 8'd1 || ctl !== 6'b001110) begin
            n_bad++; $display("FAIL rstmid_pre: word_cnt %0d ctl %b want 1 001110",
                              bus.word_cnt, ctl);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 6'b0 || bus.word_cnt !== 8'd0 || bus.data_out !== 32'd0) begin
            n_bad++; $display("FAIL rstmid_async: ctl %b word_cnt %0d data %h want 0 0 0",
                              ctl, bus.word_cnt, bus.data_out);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ctl !== 6'b100010) begin
            n_bad++; $display("FAIL rstmid_from_idle: ctl %b want 100010", ctl);
        end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] exp_cnt;
        do_reset();
        start_word($urandom);
        bus.word_valid = 1'b1;
        for (int w = 1; w <= 256; w++) begin
            bus.word_in = $urandom;
            repeat (36) tick();
            exp_cnt = w[7:0];
            n_cmp++;
            if (bus.word_cnt !== exp_cnt) begin
                n_bad++; $display("FAIL wrap_word_cnt: after word %0d got %0d want %0d",
                                  w, bus.word_cnt, exp_cnt);
            end
            if (w == 255) bus.word_valid = 1'b0;
        end
        n_cmp++;
        if (ctl !== 6'b100010) begin
            n_bad++; $display("FAIL wrap_end: ctl %b want 100010", ctl);
        end
    endtask

    initial begin
        mon_clear();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_nack_byte2();
        test_nack_last();
        test_stop_byte3();
        test_reset_mid();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
